// File: rtl/sc_liveslevels_counter_pkg.sv
// Shared game constants for the lives/levels counter and the general FSM.
// Holds the count width and the default lives/level limits.
package sc_liveslevels_counter_pkg;

  localparam int CNT_W          = 3;
  localparam int INIT_LIVES_DEF = 3;
  localparam int MAX_LEVEL_DEF  = 5;

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    cnt_t lives;
    cnt_t level;
    logic up;
  } cnt_state_t;

endpackage

// File: rtl/sc_liveslevels_counter_if.sv
// Request/status bundle between the general FSM and the counter.
// master = FSM side, slave = counter side.
interface sc_liveslevels_counter_if;
  import sc_liveslevels_counter_pkg::*;

  logic SC_LIVESLEVELS_COUNTER_NewGame_InLow;
  logic SC_LIVESLEVELS_COUNTER_contador_vidas_InLow;
  logic SC_LIVESLEVELS_COUNTER_contador_niveles_InLow;
  cnt_t SC_LIVESLEVELS_COUNTER_Lives_Out;
  cnt_t SC_LIVESLEVELS_COUNTER_Level_Out;
  logic SC_LIVESLEVELS_COUNTER_COMPARATOR_LIVES;
  logic SC_LIVESLEVELS_COUNTER_COMPARATOR_LEVELS;
  logic SC_LIVESLEVELS_COUNTER_LevelUp_OutHigh;

  modport master (
    output SC_LIVESLEVELS_COUNTER_NewGame_InLow,
    output SC_LIVESLEVELS_COUNTER_contador_vidas_InLow,
    output SC_LIVESLEVELS_COUNTER_contador_niveles_InLow,
    input  SC_LIVESLEVELS_COUNTER_Lives_Out,
    input  SC_LIVESLEVELS_COUNTER_Level_Out,
    input  SC_LIVESLEVELS_COUNTER_COMPARATOR_LIVES,
    input  SC_LIVESLEVELS_COUNTER_COMPARATOR_LEVELS,
    input  SC_LIVESLEVELS_COUNTER_LevelUp_OutHigh
  );

  modport slave (
    input  SC_LIVESLEVELS_COUNTER_NewGame_InLow,
    input  SC_LIVESLEVELS_COUNTER_contador_vidas_InLow,
    input  SC_LIVESLEVELS_COUNTER_contador_niveles_InLow,
    output SC_LIVESLEVELS_COUNTER_Lives_Out,
    output SC_LIVESLEVELS_COUNTER_Level_Out,
    output SC_LIVESLEVELS_COUNTER_COMPARATOR_LIVES,
    output SC_LIVESLEVELS_COUNTER_COMPARATOR_LEVELS,
    output SC_LIVESLEVELS_COUNTER_LevelUp_OutHigh
  );

endinterface

// File: rtl/sc_liveslevels_counter_edgedetect.sv
// Falling-edge detector for an active-low request line.
// Sample resets high so a line already low at release fires once.
module sc_edgedetect_low (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_sig,
  output logic o_event
);

  logic r_prev;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_prev <= 1'b1;
    else       r_prev <= i_sig;
  end

  assign o_event = ~i_sig & r_prev;

endmodule

// File: rtl/sc_liveslevels_counter.sv
// Lives/levels counter: saturating lives down-count and level up-count
// driven by edge-detected active-low requests, with a level-up pulse.
module sc_liveslevels_counter
  import sc_liveslevels_counter_pkg::*;
#(
  parameter int INIT_LIVES = INIT_LIVES_DEF,
  parameter int MAX_LEVEL  = MAX_LEVEL_DEF
) (
  input logic SC_LIVESLEVELS_COUNTER_CLOCK_50,
  input logic SC_LIVESLEVELS_COUNTER_RESET_InHigh,
  sc_liveslevels_counter_if.slave bus
);

  localparam cnt_t LP_INIT = cnt_t'(INIT_LIVES);
  localparam cnt_t LP_MAX  = cnt_t'(MAX_LEVEL);

  logic       w_clk;
  logic       w_rst;
  logic       w_ev_life;
  logic       w_ev_lvl;
  logic       w_lvl_ok;
  cnt_state_t r_st;

  assign w_clk = SC_LIVESLEVELS_COUNTER_CLOCK_50;
  assign w_rst = SC_LIVESLEVELS_COUNTER_RESET_InHigh;

  sc_edgedetect_low u_ed_vidas (
    .i_clk   (w_clk),
    .i_rst   (w_rst),
    .i_sig   (bus.SC_LIVESLEVELS_COUNTER_contador_vidas_InLow),
    .o_event (w_ev_life)
  );

  sc_edgedetect_low u_ed_niveles (
    .i_clk   (w_clk),
    .i_rst   (w_rst),
    .i_sig   (bus.SC_LIVESLEVELS_COUNTER_contador_niveles_InLow),
    .o_event (w_ev_lvl)
  );

  // Level gate uses pre-update lives, so a same-cycle last life blocks nothing.
  assign w_lvl_ok = w_ev_lvl
                  & (r_st.lives != '0)
                  & (r_st.level != LP_MAX);

  always_ff @(posedge w_clk) begin
    if (w_rst) begin
      r_st.lives <= LP_INIT;
      r_st.level <= '0;
      r_st.up    <= 1'b0;
    end else if (!bus.SC_LIVESLEVELS_COUNTER_NewGame_InLow) begin
      r_st.lives <= LP_INIT;
      r_st.level <= '0;
      r_st.up    <= 1'b0;
    end else begin
      if (w_ev_life && r_st.lives != '0)
        r_st.lives <= r_st.lives - cnt_t'(1);
      if (w_lvl_ok)
        r_st.level <= r_st.level + cnt_t'(1);
      r_st.up <= w_lvl_ok;
    end
  end

  assign bus.SC_LIVESLEVELS_COUNTER_Lives_Out  = r_st.lives;
  assign bus.SC_LIVESLEVELS_COUNTER_Level_Out  = r_st.level;
  assign bus.SC_LIVESLEVELS_COUNTER_LevelUp_OutHigh = r_st.up;
  assign bus.SC_LIVESLEVELS_COUNTER_COMPARATOR_LIVES  = (r_st.lives != '0);
  assign bus.SC_LIVESLEVELS_COUNTER_COMPARATOR_LEVELS = (r_st.level == LP_MAX);

endmodule
